// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - tx_state_t : transmitter FSM encoding
//   - ST_*       : bit positions of the flags inside status_out
//   - calc_div   : clocks per bit derived from clock and line rate
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_BUSY  = 10;
  localparam int ST_OVF   = 11;

  // Integer divide; clamped to 1 so a misconfigured rate still yields a
  // one-clock bit instead of a zero-width counter.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / baud;
    if (d < 1) begin
      d = 1;
    end else begin
      d = d;
    end
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO. Head data (dout) is valid whenever empty is low.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, din         write request and data (ignored when full unless a
//                     pop happens in the same cycle)
//   pop               remove head (ignored when empty)
//   dout              current head entry
//   count             occupancy, $clog2(DEPTH)+1 bits
//   full, empty       occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is still legal when the head leaves this cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset (abandons any frame)
//   uart_we     decoded bus write strobe, one cycle per write
//   P_Data      write data: [7:0] byte, [31]=1 marks a command (clears ovf)
//   status_out  {20'b0, ovf, busy, full, empty, count[7:0]}
//   txd         serial line, idle high, registered
//   busy        frame in progress
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_we,
  input  logic [31:0] P_Data,
  output logic [31:0] status_out,
  output logic        txd,
  output logic        busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state;
  tx_state_t      state_next;
  logic [BW-1:0]  baud_cnt;
  logic [BW-1:0]  baud_next;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_next;
  logic [7:0]     shreg;
  logic [7:0]     shreg_next;
  logic           txd_next;
  logic           busy_next;
  logic           ovf;
  logic           bit_done;
  logic           pop;
  logic           cmd_wr;
  logic           data_wr;

  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  assign cmd_wr   = uart_we && P_Data[31];
  assign data_wr  = uart_we && !P_Data[31];
  assign bit_done = (baud_cnt == BW'(DIV - 1));
  // Pop decision uses registered occupancy only, so a write into an empty
  // FIFO is seen one cycle later (no bypass path).
  assign pop      = (state == IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (pop),
    .din   (P_Data[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register plus baud counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= BW'(0);
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= shreg_next;
    end
  end

  // Next-state and datapath update; counter restarts on pop and bit edges.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + BW'(1);
    bit_next   = bit_idx;
    shreg_next = shreg;
    case (state)
      IDLE: begin
        baud_next = BW'(0);
        if (pop) begin
          state_next = START;
          shreg_next = fifo_dout;
          bit_next   = 3'd0;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          baud_next  = BW'(0);
          bit_next   = 3'd0;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next = BW'(0);
          bit_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            state_next = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          baud_next  = BW'(0);
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = BW'(0);
      end
    endcase
  end

  // Line level and busy for the upcoming cycle, derived from next state.
  always_comb begin
    txd_next  = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shreg_next[bit_next];
      default: txd_next = 1'b1;
    endcase
  end

  // Registered outputs and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd  <= 1'b1;
      busy <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      txd  <= txd_next;
      busy <= busy_next;
      if (cmd_wr) begin
        ovf <= 1'b0;
      end else if (data_wr && fifo_full && !pop) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end
    end
  end

  always_comb begin
    status_out           = 32'd0;
    status_out[7:0]      = 8'(fifo_count);
    status_out[ST_EMPTY] = fifo_empty;
    status_out[ST_FULL]  = fifo_full;
    status_out[ST_BUSY]  = busy;
    status_out[ST_OVF]   = ovf;
  end

endmodule
